// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - instruction/control bus between the issue side and control_sequencer
interface control_sequencer_if;
  logic       instr_valid;
  logic [7:0] opcode;
  logic       busywait;
  logic       instr_ready;
  logic       submuxsel;
  logic       immmuxsel;
  logic [2:0] aluop;
  logic       writeenable;
  logic       memread;
  logic       memwrite;
  logic       pc_update;
  logic       illegal;
  logic       timeout;

  modport master (
    output instr_valid, opcode, busywait,
    input  instr_ready, submuxsel, immmuxsel, aluop, writeenable,
           memread, memwrite, pc_update, illegal, timeout
  );

  modport slave (
    input  instr_valid, opcode, busywait,
    output instr_ready, submuxsel, immmuxsel, aluop, writeenable,
           memread, memwrite, pc_update, illegal, timeout
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle IDLE/DECODE/EXEC/MEM/WB control sequencer with memory stall abort
module control_sequencer #(
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  control_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

  localparam logic [7:0] STALL_LIMIT = 8'(BUSY_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [7:0] stall_q, stall_d;
  logic [7:0] stall_inc;
  logic [2:0] alu_fn;
  logic       is_loadi, is_sub, is_lwd, is_swd, is_defined;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= 8'h00;
      stall_q <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      stall_q <= stall_d;
    end
  end

  assign is_loadi   = (op_q == 8'h00);
  assign is_sub     = (op_q == 8'h03);
  assign is_lwd     = (op_q == 8'h06);
  assign is_swd     = (op_q == 8'h07);
  assign is_defined = (op_q < 8'h08);
  // Saturating so a long stall can never wrap back below the limit
  assign stall_inc  = (stall_q == 8'hFF) ? stall_q : stall_q + 8'd1;

  always_comb begin
    alu_fn = 3'b000;
    case (op_q)
      8'h02, 8'h03: alu_fn = 3'b001;
      8'h04:        alu_fn = 3'b010;
      8'h05:        alu_fn = 3'b011;
      default:      alu_fn = 3'b000;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    stall_d         = stall_q;
    bus.instr_ready = 1'b0;
    bus.submuxsel   = 1'b0;
    bus.immmuxsel   = 1'b0;
    bus.aluop       = 3'b000;
    bus.writeenable = 1'b0;
    bus.memread     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.pc_update   = 1'b0;
    bus.illegal     = 1'b0;
    bus.timeout     = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by reset so ready stays low while reset is held
        bus.instr_ready = reset;
        if (bus.instr_valid) begin
          op_d    = bus.opcode;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_defined) begin
          state_d = EXEC;
        end else begin
          bus.illegal   = 1'b1;
          bus.pc_update = 1'b1;
          state_d       = IDLE;
        end
      end
      EXEC: begin
        bus.aluop     = alu_fn;
        bus.submuxsel = is_sub;
        bus.immmuxsel = is_loadi;
        if (is_lwd || is_swd) begin
          stall_d = 8'h00;
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        bus.aluop    = alu_fn;
        bus.memread  = is_lwd;
        bus.memwrite = is_swd;
        if (!bus.busywait) begin
          if (is_lwd) begin
            state_d = WB;
          end else begin
            bus.pc_update = 1'b1;
            state_d       = IDLE;
          end
        end else begin
          stall_d = stall_inc;
          if (stall_inc == STALL_LIMIT) begin
            bus.timeout = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      WB: begin
        bus.aluop       = alu_fn;
        bus.submuxsel   = is_sub;
        bus.immmuxsel   = is_loadi;
        bus.writeenable = 1'b1;
        bus.pc_update   = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  control_sequencer_if bus ();
  control_sequencer_if bus4 ();

  control_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  control_sequencer #(.BUSY_TIMEOUT(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  // {ready, sub, imm, aluop[2:0], we, mr, mw, pc, illegal, timeout}
  logic [12:0] o, o4;
  assign o  = {bus.instr_ready, bus.submuxsel, bus.immmuxsel, bus.aluop, bus.writeenable,
               bus.memread, bus.memwrite, bus.pc_update, bus.illegal, bus.timeout};
  assign o4 = {bus4.instr_ready, bus4.submuxsel, bus4.immmuxsel, bus4.aluop, bus4.writeenable,
               bus4.memread, bus4.memwrite, bus4.pc_update, bus4.illegal, bus4.timeout};

  function automatic logic [12:0] ex(input logic rdy, input logic sub, input logic imm,
                                     input logic [2:0] alu, input logic we, input logic mr,
                                     input logic mw, input logic pc, input logic il, input logic to);
    return {rdy, sub, imm, alu, we, mr, mw, pc, il, to};
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] op);
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
  endtask

  initial begin
    logic [12:0] zero, rdy;
    zero = 13'd0;
    rdy  = ex(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);

    reset = 1'b0;
    bus.instr_valid = 1'b0;  bus.opcode = 8'h00;  bus.busywait = 1'b0;
    bus4.instr_valid = 1'b0; bus4.opcode = 8'h00; bus4.busywait = 1'b0;

    #3;
    chk("reset_no_clock", o, zero);
    @(negedge clk);
    chk("reset_after_edge", o, zero);
    chk("reset_after_edge_t4", o4, zero);
    reset = 1'b1;
    #1;
    chk("idle_ready", o, rdy);

    // add
    issue(8'h02);
    @(negedge clk); bus.instr_valid = 1'b0; bus.opcode = 8'h03;
    chk("add_decode", o, zero);
    @(negedge clk); chk("add_exec", o, ex(0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0));
    @(negedge clk); chk("add_wb", o, ex(0, 0, 0, 3'b001, 1, 0, 0, 1, 0, 0));
    @(negedge clk); chk("add_ready_again", o, rdy);

    // sub
    issue(8'h03);
    @(negedge clk); bus.instr_valid = 1'b0;
    chk("sub_decode", o, zero);
    @(negedge clk); chk("sub_exec", o, ex(0, 1, 0, 3'b001, 0, 0, 0, 0, 0, 0));
    @(negedge clk); chk("sub_wb", o, ex(0, 1, 0, 3'b001, 1, 0, 0, 1, 0, 0));
    @(negedge clk); chk("sub_idle", o, rdy);

    // loadi
    issue(8'h00);
    @(negedge clk); bus.instr_valid = 1'b0;
    chk("loadi_decode", o, zero);
    @(negedge clk); chk("loadi_exec", o, ex(0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0));
    @(negedge clk); chk("loadi_wb", o, ex(0, 0, 1, 3'b000, 1, 0, 0, 1, 0, 0));
    @(negedge clk); chk("loadi_idle", o, rdy);

    // lwd with five stall cycles
    issue(8'h06);
    bus.busywait = 1'b1;
    @(negedge clk); bus.instr_valid = 1'b0;
    chk("lwd_decode", o, zero);
    @(negedge clk); chk("lwd_exec", o, zero);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("lwd_mem_stall", o, ex(0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0));
    end
    bus.busywait = 1'b0;
    #1;
    chk("lwd_mem_last", o, ex(0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0));
    @(negedge clk); chk("lwd_wb", o, ex(0, 0, 0, 3'b000, 1, 0, 0, 1, 0, 0));
    @(negedge clk); chk("lwd_idle", o, rdy);

    // swd, no stall
    issue(8'h07);
    @(negedge clk); bus.instr_valid = 1'b0;
    chk("swd_decode", o, zero);
    @(negedge clk); chk("swd_exec", o, zero);
    @(negedge clk); chk("swd_mem", o, ex(0, 0, 0, 3'b000, 0, 0, 1, 1, 0, 0));
    @(negedge clk); chk("swd_idle", o, rdy);

    // undefined opcode
    issue(8'hFF);
    @(negedge clk); bus.instr_valid = 1'b0;
    chk("illegal_decode", o, ex(0, 0, 0, 3'b000, 0, 0, 0, 1, 1, 0));
    @(negedge clk); chk("illegal_idle", o, rdy);

    // swd stuck on busywait with BUSY_TIMEOUT=4
    bus4.instr_valid = 1'b1; bus4.opcode = 8'h07; bus4.busywait = 1'b1;
    @(negedge clk); bus4.instr_valid = 1'b0;
    chk("to_decode", o4, zero);
    @(negedge clk); chk("to_exec", o4, zero);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("to_mem_stall", o4, ex(0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0));
    end
    @(negedge clk); chk("to_mem_abort", o4, ex(0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 1));
    @(negedge clk); chk("to_idle", o4, rdy);
    bus4.busywait = 1'b0;

    // reset in the middle of an lwd memory stall
    issue(8'h06);
    bus.busywait = 1'b1;
    @(negedge clk); bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("rst_mem_before", o, ex(0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0));
    #2 reset = 1'b0;
    #1 chk("rst_async_zero", o, zero);
    bus.busywait = 1'b0;
    @(negedge clk); chk("rst_held", o, zero);
    reset = 1'b1;
    @(negedge clk); chk("rst_release_ready", o, rdy);
    @(negedge clk); chk("rst_no_wb", o, rdy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter BUSY_TIMEOUT, default 255: maximum consecutive BUSYWAIT-high cycles in MEM before abort (1..255).
REQ-002 SHALL have ports, clock and reset first:
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- INSTR_VALID  in  1  instruction available.
- OPCODE  in  8  instruction opcode.
- BUSYWAIT  in  1  data memory stall.
- INSTR_READY  out  1  sequencer can accept an instruction.
- SUBMUXSEL  out  1  selects two's-complement operand (1) or register operand (0).
- IMMMUXSEL  out  1  selects immediate (1) or non-immediate operand (0).
- ALUOP  out  3  ALU function.
- WRITEENABLE  out  1  register file write strobe.
- MEMREAD  out  1  data memory read request.
- MEMWRITE  out  1  data memory write request.
- PC_UPDATE  out  1  one-cycle instruction-retired pulse.
- ILLEGAL  out  1  one-cycle undefined-opcode pulse.
- TIMEOUT  out  1  one-cycle memory-abort pulse.

Function
REQ-003 SHALL implement states IDLE, DECODE, EXEC, MEM and WB.
REQ-004 INSTR_READY SHALL be 1 only in IDLE; an instruction is accepted at a rising edge with INSTR_VALID=1 and INSTR_READY=1, OPCODE latched, IDLE->DECODE.
REQ-005 The latched opcode SHALL hold until return to IDLE; OPCODE changes after acceptance have no effect.
REQ-006 Opcode decode SHALL be: 0x00 loadi, 0x01 mov, 0x02 add, 0x03 sub, 0x04 and, 0x05 or, 0x06 lwd, 0x07 swd; all others undefined.
REQ-007 DECODE SHALL last one cycle; defined opcode -> EXEC; undefined -> IDLE with ILLEGAL=1 and PC_UPDATE=1 for that DECODE cycle only.
REQ-008 ALUOP SHALL be 000 for loadi/mov/lwd/swd, 001 for add/sub, 010 for and, 011 for or, and 000 outside EXEC/MEM/WB.
REQ-009 SUBMUXSEL SHALL be 1 exactly in EXEC and WB of a sub instruction; IMMMUXSEL SHALL be 1 exactly in EXEC and WB of loadi; both 0 otherwise.
REQ-010 EXEC SHALL last one cycle; loadi/mov/add/sub/and/or -> WB; lwd/swd -> MEM.
REQ-011 In MEM, MEMREAD (lwd) or MEMWRITE (swd) SHALL be 1 every cycle; MEM SHALL exit at the first edge where BUSYWAIT=0: lwd -> WB; swd -> IDLE with PC_UPDATE=1 in that final MEM cycle.
REQ-012 An 8-bit stall counter SHALL clear on MEM entry and increment each MEM cycle with BUSYWAIT=1; in the cycle where it reaches BUSY_TIMEOUT with BUSYWAIT still 1, TIMEOUT=1, PC_UPDATE=0 and the next state is IDLE. The counter SHALL NOT wrap.
REQ-013 WB SHALL last one cycle with WRITEENABLE=1 and PC_UPDATE=1, then -> IDLE.
REQ-014 ALU-class latency: accept at edge t0; DECODE t0-t1; EXEC t1-t2; WB t2-t3; INSTR_READY=1 again after t3, i.e. 4 cycles per instruction with back-to-back INSTR_VALID.
REQ-015 WRITEENABLE, MEMREAD and MEMWRITE SHALL never be 1 in the same cycle; PC_UPDATE, ILLEGAL and TIMEOUT SHALL each be single-cycle pulses.

Reset
REQ-016 While RESET=0: state IDLE, latched opcode 0x00, stall counter 0, and every output 0, including INSTR_READY, independent of CLK.
REQ-017 RESET asserted in any state SHALL abort the instruction immediately with no WRITEENABLE, PC_UPDATE or memory request afterwards; INSTR_READY=1 from the first cycle after release.

Verification
REQ-018 Bench SHALL cover:
- add (0x02) accepted -> ALUOP=001 in EXEC/WB, SUBMUXSEL=0, WRITEENABLE+PC_UPDATE in the 3rd cycle after acceptance, INSTR_READY back after 4 cycles.
- sub (0x03) -> SUBMUXSEL=1 only in EXEC and WB, ALUOP=001; loadi (0x00) -> IMMMUXSEL=1 in EXEC and WB, ALUOP=000.
- lwd (0x06) with BUSYWAIT high 5 cycles -> MEMREAD high 6 cycles, then a WB cycle with WRITEENABLE=1; swd (0x07) -> MEMWRITE, then PC_UPDATE with no WRITEENABLE.
- BUSY_TIMEOUT=4, swd with BUSYWAIT stuck high -> TIMEOUT pulse in the 4th MEM cycle, return to IDLE, no PC_UPDATE.
- OPCODE 0xFF -> ILLEGAL and PC_UPDATE pulse in DECODE, no WRITEENABLE, IDLE next.
- RESET low mid-MEM during lwd -> all outputs 0 asynchronously, no WB; INSTR_READY=1 one cycle after release.
